key_lookup_scan: RTL and testbench

KEY_LOOKUP_SCAN -- requirements
Module: key_lookup_scan

---
 rtl/ctrl_types_pkg.sv | 15 +
 rtl/key_lookup_scan_if.sv | 26 ++
 rtl/key_cmp_lane.sv | 11 +
 rtl/key_lookup_scan.sv | 117 +++++++++++
 tb/tb_key_lookup_scan.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_types_pkg.sv
// Shared control types for the key lookup scan engine.
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } lookup_state_e;

  // Counter width for n chunks, never narrower than one bit.
  function automatic int unsigned chunk_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_lookup_scan_if.sv
// Request/result bundle between the lookup requester and key_lookup_scan.
interface key_lookup_scan_if #(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned KEY_WIDTH   = 64
);
  logic                             start;
  logic [KEY_WIDTH-1:0]             key_in;
  logic [NUM_ENTRIES*KEY_WIDTH-1:0] keys;
  logic [NUM_ENTRIES-1:0]           used;
  logic                             busy;
  logic                             done;
  logic                             hit;
  logic [NUM_ENTRIES-1:0]           idx_out;
  logic [NUM_ENTRIES-1:0]           used_out;
  logic                             multi_hit;

  modport master (
    output start, key_in, keys, used,
    input  busy, done, hit, idx_out, used_out, multi_hit
  );

  modport slave (
    input  start, key_in, keys, used,
    output busy, done, hit, idx_out, used_out, multi_hit
  );
endinterface

// File: rtl/key_cmp_lane.sv
// One comparator lane: matches when the entry is valid and the keys are equal.
module key_cmp_lane #(
  parameter int unsigned KEY_WIDTH = 64
) (
  input  logic [KEY_WIDTH-1:0] key_a,
  input  logic [KEY_WIDTH-1:0] key_b,
  input  logic                 valid,
  output logic                 match
);
  assign match = valid && (key_a == key_b);
endmodule

// File: rtl/key_lookup_scan.sv
// Multi-cycle associative key lookup: scans LANES entries per cycle, reports
// the lowest matching entry one-hot and flags duplicate matches.
module key_lookup_scan
  import ctrl_types_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned KEY_WIDTH   = 64,
  parameter int unsigned LANES       = 4
) (
  input logic             clk,
  input logic             rst_n,
  key_lookup_scan_if.slave bus
);
  localparam int unsigned NUM_CHUNKS = NUM_ENTRIES / LANES;
  localparam int unsigned CW         = chunk_width(NUM_CHUNKS);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

  lookup_state_e          state_q, state_d;
  logic [CW-1:0]          chunk_q, chunk_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [NUM_ENTRIES-1:0] used_q, used_d;
  logic                   hit_q, hit_d;
  logic [NUM_ENTRIES-1:0] idx_q, idx_d;
  logic                   multi_q, multi_d;

  logic [LANES*KEY_WIDTH-1:0] chunk_keys;
  logic [LANES-1:0]           chunk_used;
  logic [LANES-1:0]           lane_match;

  // Bring the current chunk down to lane 0 so each lane sees a fixed slice.
  assign chunk_keys = (LANES*KEY_WIDTH)'(bus.keys >> (32'(chunk_q) * LANES * KEY_WIDTH));
  assign chunk_used = LANES'(used_q >> (32'(chunk_q) * LANES));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    key_cmp_lane #(.KEY_WIDTH(KEY_WIDTH)) u_lane (
      .key_a (key_q),
      .key_b (chunk_keys[l*KEY_WIDTH +: KEY_WIDTH]),
      .valid (chunk_used[l]),
      .match (lane_match[l])
    );
  end

  always_comb begin
    logic found;
    state_d = state_q;
    chunk_d = chunk_q;
    key_d   = key_q;
    used_d  = used_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    found   = hit_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d   = bus.key_in;
          used_d  = bus.used;
          chunk_d = '0;
          hit_d   = 1'b0;
          idx_d   = '0;
          multi_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Lanes are visited low to high so the first match in a chunk wins.
        for (int unsigned l = 0; l < LANES; l++) begin
          if (lane_match[l]) begin
            if (found) begin
              multi_d = 1'b1;
            end else begin
              hit_d = 1'b1;
              idx_d = NUM_ENTRIES'(1) << (32'(chunk_q) * LANES + l);
              found = 1'b1;
            end
          end
        end
        if (chunk_q == LAST_CHUNK) begin
          chunk_d = '0;
          state_d = DONE;
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chunk_q <= '0;
      key_q   <= '0;
      used_q  <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      key_q   <= key_d;
      used_q  <= used_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      multi_q <= multi_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.hit       = hit_q;
  assign bus.idx_out   = idx_q;
  assign bus.used_out  = used_q;
  assign bus.multi_hit = multi_q;

endmodule

// File: tb/tb_key_lookup_scan.sv
// Scoreboard bench for key_lookup_scan with 16 entries, 64-bit keys, 4 lanes.
module tb_key_lookup_scan;
  localparam int unsigned NE  = 16;
  localparam int unsigned KW  = 64;
  localparam int          LAT = 5;

  typedef struct {
    logic        hit;
    logic [15:0] idx;
    logic [15:0] uo;
    logic        multi;
    int          start_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   done_count;
  int   exp_dones;
  exp_t q[$];

  key_lookup_scan_if #(.NUM_ENTRIES(NE), .KEY_WIDTH(KW)) bus ();

  key_lookup_scan #(.NUM_ENTRIES(NE), .KEY_WIDTH(KW), .LANES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_base();
    for (int i = 0; i < int'(NE); i++) bus.keys[i*KW +: KW] = 64'h1000 + 64'(i);
  endtask

  task automatic set_key(input int i, input logic [63:0] v);
    bus.keys[i*KW +: KW] = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        done_count++;
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = q.pop_front();
          chk("latency", 64'(cyc - e.start_cyc), 64'(LAT));
          chk("hit", 64'(bus.hit), 64'(e.hit));
          chk("idx_out", 64'(bus.idx_out), 64'(e.idx));
          chk("used_out", 64'(bus.used_out), 64'(e.uo));
          chk("multi_hit", 64'(bus.multi_hit), 64'(e.multi));
        end
      end
    end
  endtask

  task automatic wait_done(input int d0);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step(1);
      if (done_count != d0) got = 1'b1;
    end
    chk("done_arrived", 64'(got), 64'd1);
    if (!got) q.delete();
  endtask

  task automatic run_lookup(input logic [63:0] k, input logic [15:0] u,
                            input logic h, input logic [15:0] ix, input logic m);
    int d0;
    step(1);
    bus.key_in = k;
    bus.used   = u;
    bus.start  = 1'b1;
    q.push_back('{h, ix, u, m, cyc});
    exp_dones++;
    d0 = done_count;
    step(1);
    bus.start = 1'b0;
    wait_done(d0);
    step(1);
  endtask

  task automatic driver();
    int c0;
    int d0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.keys = '0;
    bus.used = '0;
    step(3);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hit", 64'(bus.hit), 64'd0);
    chk("rst_idx", 64'(bus.idx_out), 64'd0);
    chk("rst_used_out", 64'(bus.used_out), 64'd0);
    chk("rst_multi", 64'(bus.multi_hit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single hit in entry 5, then results must hold while inputs change.
    set_base();
    set_key(5, 64'hDEAD);
    run_lookup(64'hDEAD, 16'h00FF, 1'b1, 16'h0020, 1'b0);
    bus.used = 16'h0000;
    set_key(5, 64'h0);
    step(3);
    chk("hold_hit", 64'(bus.hit), 64'd1);
    chk("hold_idx", 64'(bus.idx_out), 64'h0020);
    chk("hold_used_out", 64'(bus.used_out), 64'h00FF);
    chk("hold_multi", 64'(bus.multi_hit), 64'd0);

    // Key present only in an unused slot.
    set_base();
    set_key(0, 64'h1111);
    set_key(3, 64'hBEEF);
    run_lookup(64'hBEEF, 16'h0001, 1'b0, 16'h0000, 1'b0);

    // Duplicate match across chunks.
    set_base();
    set_key(2, 64'hCAFE);
    set_key(13, 64'hCAFE);
    run_lookup(64'hCAFE, 16'hFFFF, 1'b1, 16'h0004, 1'b1);

    // Full cache, no match.
    set_base();
    run_lookup(64'hABCD, 16'hFFFF, 1'b0, 16'h0000, 1'b0);

    // Nothing used: key equal to entry 0 still misses.
    run_lookup(64'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Duplicate within one chunk.
    set_key(4, 64'h5555);
    set_key(5, 64'h5555);
    run_lookup(64'h5555, 16'h0030, 1'b1, 16'h0010, 1'b1);

    // Hit in the last entry; an equal unused entry must not count.
    set_base();
    set_key(7, 64'hF0F0);
    set_key(15, 64'hF0F0);
    run_lookup(64'hF0F0, 16'h8000, 1'b1, 16'h8000, 1'b0);

    // Starts while busy and during DONE are ignored.
    set_base();
    set_key(5, 64'hDEAD);
    step(1);
    bus.key_in = 64'hDEAD;
    bus.used   = 16'h00FF;
    bus.start  = 1'b1;
    c0 = cyc;
    q.push_back('{1'b1, 16'h0020, 16'h00FF, 1'b0, c0});
    exp_dones++;
    d0 = done_count;
    step(1);
    bus.start = 1'b0;
    step(1);
    chk("busy_mid_scan", 64'(bus.busy), 64'd1);
    bus.key_in = 64'h1003;
    bus.used   = 16'hFFFF;
    bus.start  = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(c0 + LAT - cyc);
    chk("done_cycle", 64'(bus.done), 64'd1);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(2);
    chk("busy_after_done_start", 64'(bus.busy), 64'd0);
    chk("single_done", 64'(done_count - d0), 64'd1);

    // Reset in the middle of a scan aborts without a done pulse.
    set_base();
    step(1);
    bus.key_in = 64'h1001;
    bus.used   = 16'hFFFF;
    bus.start  = 1'b1;
    c0 = cyc;
    d0 = done_count;
    step(1);
    bus.start = 1'b0;
    step(c0 + 3 - cyc);
    chk("pre_reset_hit", 64'(bus.hit), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_hit", 64'(bus.hit), 64'd0);
    chk("mid_rst_idx", 64'(bus.idx_out), 64'd0);
    chk("mid_rst_used_out", 64'(bus.used_out), 64'd0);
    chk("mid_rst_multi", 64'(bus.multi_hit), 64'd0);
    step(4);
    chk("no_done_after_abort", 64'(done_count - d0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_key(5, 64'hDEAD);
    run_lookup(64'hDEAD, 16'h00FF, 1'b1, 16'h0020, 1'b0);

    step(3);
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("total_dones", 64'(done_count), 64'(exp_dones));
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    done_count = 0;
    exp_dones = 0;
    fork
      monitor();
      driver();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
